// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if -- word-side bus of the UART word receiver.
//   word_out   : assembled 16-bit word, high byte received first
//   word_valid : word_out holds an unconsumed word
//   word_ready : consumer accepts word_out (handshake with word_valid)
//   frame_err  : one-cycle pulse on a rejected byte
//   overrun    : one-cycle pulse when a completed word is dropped
// Modport master is the receiver side, slave is the consumer side.
interface uart_word_rx_if;
   logic [15:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic        frame_err;
   logic        overrun;

   modport master (
      output word_out,
      output word_valid,
      output frame_err,
      output overrun,
      input  word_ready
   );

   modport slave (
      input  word_out,
      input  word_valid,
      input  frame_err,
      input  overrun,
      output word_ready
   );
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx -- UART receiver that pairs bytes into 16-bit words.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   ce   : clock enable, all state holds while low
//   rx   : serial line, idle high, asynchronous to clk
//   bus  : uart_word_rx_if.master (word_out/word_valid/word_ready/
//          frame_err/overrun)
// Parameters: CE_PER_BIT (ce cycles per bit, 4..65535), GAP_BITS (idle bit
// periods after a high byte before the half word is dropped).
// Optional feature: define UART_WORD_RX_PARITY_EN for 8E1 framing (even
// parity bit after bit 7); otherwise 8N1.
module uart_word_rx #(
   parameter int CE_PER_BIT = 868,
   parameter int GAP_BITS   = 20
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           rx,
   uart_word_rx_if.master bus
);

   localparam logic [15:0] HALF_BIT = 16'(CE_PER_BIT / 2);
   localparam logic [15:0] BIT_LEN  = 16'(CE_PER_BIT);
   localparam logic [23:0] GAP_LAST = 24'(GAP_BITS * CE_PER_BIT - 1);

`ifdef UART_WORD_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // High when the data bits plus the parity bit carry an odd number of ones.
   function automatic logic even_par_bad(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  sync_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  high_q, high_d;
   logic        half_q, half_d;
   logic [23:0] gap_q, gap_d;
   logic [15:0] word_q, word_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
`ifdef UART_WORD_RX_PARITY_EN
   logic        par_err_q, par_err_d;
`endif

   logic rx_s;
   logic expire_s;
   logic consume_s;
   logic accept_s;
   logic discard_s;
   logic complete_s;

   assign rx_s      = sync_q[1];
   // Counter is reloaded on the cycle it would reach zero, so a value of 1 marks the sample point.
   assign expire_s  = (cnt_q <= 16'd1);
   assign consume_s = valid_q & bus.word_ready;

   // Register bank: synchronizer, FSM state and datapath, all gated by ce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= 2'b11;
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         high_q    <= 8'd0;
         half_q    <= 1'b0;
         gap_q     <= 24'd0;
         word_q    <= 16'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else if (ce) begin
         sync_q    <= {sync_q[0], rx};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         high_q    <= high_d;
         half_q    <= half_d;
         gap_q     <= gap_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef UART_WORD_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   // Next-state logic: frame FSM, byte pairing, gap timer and output word.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      high_d     = high_q;
      half_d     = half_q;
      gap_d      = gap_q;
      word_d     = word_q;
      valid_d    = valid_q;
      ferr_d     = 1'b0;
      ovr_d      = 1'b0;
      accept_s   = 1'b0;
      discard_s  = 1'b0;
      complete_s = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
      par_err_d  = par_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF_BIT;
            end else begin
               state_d = IDLE;
               cnt_d   = 16'd0;
            end
         end
         START: begin
            if (expire_s) begin
               bit_d = 3'd0;
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = BIT_LEN;
               end else begin
                  // Start bit vanished by mid-bit: treat as a glitch.
                  state_d = IDLE;
                  cnt_d   = 16'd0;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (expire_s) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = BIT_LEN;
               if (bit_q == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef UART_WORD_RX_PARITY_EN
         PARITY: begin
            if (expire_s) begin
               // Verdict is held until the stop bit so both errors share one discard path.
               par_err_d = even_par_bad(shift_q, rx_s);
               cnt_d     = BIT_LEN;
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`endif
         STOP: begin
            if (expire_s) begin
               state_d = IDLE;
               cnt_d   = 16'd0;
`ifdef UART_WORD_RX_PARITY_EN
               if (rx_s && !par_err_q) begin
`else
               if (rx_s) begin
`endif
                  accept_s = 1'b1;
               end else begin
                  discard_s = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      // Byte pairing: first good byte is the high half, second completes the word.
      if (discard_s) begin
         ferr_d = 1'b1;
         half_d = 1'b0;
      end else if (accept_s) begin
         if (half_q) begin
            half_d     = 1'b0;
            complete_s = 1'b1;
         end else begin
            half_d = 1'b1;
            high_d = shift_q;
         end
      end else begin
         half_d = half_q;
      end

      // Gap timer only runs while waiting in IDLE with a pending high byte.
      if ((state_q == IDLE) && (state_d == IDLE) && half_q) begin
         if (gap_q >= GAP_LAST) begin
            half_d = 1'b0;
            gap_d  = 24'd0;
         end else begin
            gap_d = gap_q + 24'd1;
         end
      end else begin
         gap_d = 24'd0;
      end

      // A consume in the same cycle frees the slot for a completing word.
      if (complete_s) begin
         if (!valid_q || consume_s) begin
            word_d  = {high_q, shift_q};
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (consume_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_valid = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 Parameter CE_PER_BIT, default 868, is the number of ce-qualified clk cycles per UART bit; legal values are 4 to 65535.
REQ-002 Parameter GAP_BITS, default 20, is the number of bit periods of idle line after a high byte before the partial word is discarded.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port ce, input, 1 bit: clock enable; when ce=0 every register holds its value.
REQ-006 Port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 Port word_out, output, 16 bits: assembled word, high byte received first.
REQ-008 Port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-009 Port word_ready, input, 1 bit: boot_loader accepts word_out.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit (and on bad parity when enabled).
REQ-011 Port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-012 rx passes through a 2-flop synchronizer preset to 1; only the synchronized value is used.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
REQ-014 IDLE->START on synchronized rx=0; the bit counter is loaded with CE_PER_BIT/2 (integer division).
REQ-015 START: at counter expiry, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no flags raised).
REQ-016 DATA: sample every CE_PER_BIT ce-cycles at mid-bit, 8 bits, LSB first; after bit 7 go to PARITY or STOP.
REQ-017 STOP: sample at mid-bit; if rx=1 the byte is accepted, else the byte is discarded, frame_err pulses, and the half-word is cleared; both cases -> IDLE.
REQ-018 The first accepted byte is latched as the high byte and the half flag is set; the second accepted byte completes the word {high, low} and clears the half flag.
REQ-019 On completion with word_valid=0: word_out is loaded and word_valid=1 on the same ce-cycle as the STOP sample.
REQ-020 On completion with word_valid=1 and no handshake in that cycle: the new word is dropped, overrun pulses, and word_out is unchanged.
REQ-021 Handshake: word_valid=1 and word_ready=1 with ce=1 consumes the word.
REQ-022 A completion in the same cycle as a consume loads the new word, keeps word_valid=1, and does not raise overrun.
REQ-023 word_valid is cleared only by a consume; word_out is stable while word_valid=1.
REQ-024 Gap timer: while the half flag is set and the FSM is IDLE, count ce-cycles; at GAP_BITS*CE_PER_BIT cycles the half flag clears silently.
REQ-025 The gap timer resets whenever the FSM leaves IDLE.
REQ-026 Counter widths: the bit counter is 16 bits and the gap counter is 24 bits; neither counter wraps.

Reset
REQ-027 rst=1 immediately forces state IDLE, synchronizer 1, all counters 0, half flag 0, word_out 0x0000, word_valid 0, frame_err 0, overrun 0.
REQ-028 Reset mid-frame abandons the frame; after release, reception restarts at the next falling edge and the first byte is taken as a high byte.

Configuration
REQ-029 Macro UART_WORD_RX_PARITY_EN defined: an even-parity bit follows bit 7 and is sampled in state PARITY.
REQ-030 With the macro defined, a parity mismatch discards the byte, pulses frame_err, and clears the half flag, as for a bad stop bit.
REQ-031 With the macro undefined: 8N1 framing; the PARITY state and its logic are absent.

Verification (CE_PER_BIT=4, GAP_BITS=20, ce=1 unless stated)
REQ-032 Bytes 0x12 then 0x34 sent 8N1 -> word_out=0x1234 and word_valid=1; it clears one cycle after word_ready=1.
REQ-033 rx low for 1 ce-cycle only -> the FSM returns to IDLE; no word_valid, no frame_err.
REQ-034 Byte 0xAB with stop bit 0, then 0xCD, 0xEF -> frame_err pulses once; word_out=0xCDEF.
REQ-035 Word 0x1111 held (word_ready=0), then 0x2222 sent -> overrun pulses once; word_out stays 0x1111.
REQ-036 Byte 0x55, idle 81 bit-times, then 0x66, 0x77 -> word_out=0x6677.
REQ-037 rst pulsed during bit 3 of 0x99, then 0x01, 0x02 sent -> word_out=0x0102; with the parity macro defined, 0x01 with odd parity -> frame_err pulses.
